gcd_unit_param: RTL and testbench
=================================

Name: gcd_unit_param

Overview:
- Parametrised-width iterative GCD engine with val/rdy request and response interfaces.
- Request = two NBITS operands; response = one NBITS result.
- Successor to the fixed 16-bit unit. Adds a one-entry input buffer so the next request is accepted during a calculation.
- On completion it chains straight into the next calculation without an idle cycle.
- Defines results for zero operands.

Parameters:
- NBITS, 16, operand/result width (>=2)
- ITER_NBITS, 8, width of the iteration counter (optional feature only)

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset (asserted = 0)
- recv_val  in  1  request valid
- recv_rdy  out  1  request ready
- recv_msg  in  2*NBITS  {opA[2*NBITS-1:NBITS], opB[NBITS-1:0]}
- send_val  out  1  response valid
- send_rdy  in  1  response ready
- send_msg  out  NBITS  GCD result
- send_iters  out  ITER_NBITS  calc-cycle count (only with GCD_UNIT_PARAM_ITER_COUNT_EN)

Behaviour:

Registers and handshakes:
- Registers: a_reg, b_reg (NBITS); buf_val, buf_msg (one-entry input buffer); state in {IDLE, CALC, DONE}.
- Reset asserted, asynchronously: state=IDLE, a_reg=b_reg=0, buf_val=0, buf_msg=0, counter=0.
- Outputs during and right after reset: recv_rdy=1, send_val=0, send_msg=0.
- recv_rdy = ~buf_val, in every state. req_go = recv_val & recv_rdy.
- resp_go = send_val & send_rdy.
- send_msg = a_reg in all states; valid only when send_val=1.

IDLE:
- If buf_val: load a/b from buf_msg, clear buf_val, go to CALC.
- Else if req_go: load a/b directly from recv_msg (bypass; buffer stays empty), go to CALC.
- Else hold.

CALC, one step per cycle:
- b_reg==0: send_val=1 (Mealy).
  - resp_go: if buf_val, load the buffer into a/b, clear buf_val, stay in CALC. Otherwise go to IDLE.
  - No resp_go: go to DONE.
- a_reg<b_reg: a<=b-a, b<=a (swap-and-subtract).
- Otherwise: a<=a-b, b unchanged.

DONE:
- send_val=1; a/b held.
- resp_go: same chaining rule as the completing CALC cycle (buffer -> CALC, else IDLE).

Buffer and arithmetic:
- A request arriving while the engine is busy (state!=IDLE, or same-cycle load from the buffer) writes buf_msg and sets buf_val.
- Buffer write and buffer drain in the same cycle are impossible: drain only occurs when buf_val=1, so recv_rdy=0.
- Arithmetic is unsigned modulo 2^NBITS, with no overflow possible (subtract only the smaller from the larger).
- Zero operands: gcd(0,0)=0, gcd(0,x)=x, gcd(x,0)=x.

Latency and ordering:
- Bypass accept in cycle N (IDLE) -> first CALC cycle N+1.
- A result appears in the cycle b_reg becomes 0.
- Back-to-back results are separated by zero idle cycles when the buffer is full.
- Responses are returned in request order.
- Reset mid-calculation discards in-flight and buffered requests; no response is produced for them.

Optional Feature:
Macro GCD_UNIT_PARAM_ITER_COUNT_EN.
- Defined: send_iters port exists. Counter clears when a/b are loaded (bypass or buffer). It increments in each CALC cycle with b_reg!=0 and saturates at 2^ITER_NBITS-1.
- send_iters = counter + 1 in the completing CALC cycle (saturating); the registered value is then held in DONE. This counts calc cycles including the result cycle.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then gcd(15,5), send_rdy=1 -> send_msg=5 valid 5 cycles after accept; send_iters=5 if enabled.
- Zero operands (0,0), (0,7), (9,0) -> results 0, 7, 9; (0,0) valid in the first CALC cycle.
- Back-to-back: (27,15) then (49,21) presented during the first calc -> recv_rdy drops once the buffer is full; results 3 then 7 with no IDLE cycle between; a third request is accepted only after the buffer drains.
- Backpressure: send_rdy=0 for 4 cycles on a result of 6 -> state DONE; send_msg stays 6 with send_val=1; released exactly on the send_rdy=1 cycle.
- NBITS=32: gcd(0xFFFFFFFE, 0x00000002) -> 2; no wrap errors. NBITS=8: gcd(255,17) -> 17.
- Async reset asserted mid-CALC with buffer full (negedge not aligned to clk) -> send_val=0 and recv_rdy=1 immediately; the next request after release computes correctly.

Source files
------------

// File: rtl/gcd_unit_param.sv
// gcd_unit_param: iterative subtractive GCD with val/rdy and a 1-entry input buffer.
// Optional calc-cycle counter on send_iters: define GCD_UNIT_PARAM_ITER_COUNT_EN.
module gcd_unit_param #(
  parameter int NBITS      = 16,
  parameter int ITER_NBITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [2*NBITS-1:0]   recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [NBITS-1:0]     send_msg
`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
  ,
  output logic [ITER_NBITS-1:0] send_iters
`endif
);

  if (NBITS < 2 || ITER_NBITS < 1) begin : g_bad_cfg
    $error("gcd_unit_param: NBITS >= 2 and ITER_NBITS >= 1 required");
  end

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state, state_n;
  logic [NBITS-1:0]   a_reg, b_reg, a_n, b_n;
  logic               buf_val;
  logic [2*NBITS-1:0] buf_msg, src_msg;
  logic req_go, resp_go, b_zero, calc;
  logic load_buf, load_req, load, buf_wr;

  assign recv_rdy = ~buf_val;
  assign req_go   = recv_val & recv_rdy;
  assign calc     = (state == CALC);
  assign b_zero   = (b_reg == '0);
  assign send_val = (state == DONE) | (calc & b_zero);
  assign resp_go  = send_val & send_rdy;
  assign send_msg = a_reg;

  // Buffer drains on IDLE or on a consumed result; a request while busy fills it.
  assign load_buf = buf_val & ((state == IDLE) | resp_go);
  assign load_req = req_go & (state == IDLE);
  assign load     = load_buf | load_req;
  assign buf_wr   = req_go & (state != IDLE);
  assign src_msg  = load_buf ? buf_msg : recv_msg;

  always_comb begin
    state_n = state;
    a_n     = a_reg;
    b_n     = b_reg;
    unique case (1'b1)
      load: begin
        state_n = CALC;
        a_n     = src_msg[2*NBITS-1:NBITS];
        b_n     = src_msg[NBITS-1:0];
      end
      resp_go & ~buf_val: state_n = IDLE;
      calc & b_zero & ~resp_go: state_n = DONE;
      calc & ~b_zero: begin
        if (a_reg < b_reg) begin
          a_n = b_reg - a_reg;
          b_n = a_reg;
        end else begin
          a_n = a_reg - b_reg;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      buf_val <= 1'b0;
      buf_msg <= '0;
    end else begin
      state <= state_n;
      a_reg <= a_n;
      b_reg <= b_n;
      if (load_buf)
        buf_val <= 1'b0;
      else if (buf_wr)
        buf_val <= 1'b1;
      if (buf_wr)
        buf_msg <= recv_msg;
    end
  end

`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
  logic [ITER_NBITS-1:0] cnt, cnt_inc;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + ITER_NBITS'(1);
  // The completing cycle also counts, so DONE holds the full total.
  assign send_iters = calc ? cnt_inc : cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (load)
      cnt <= '0;
    else if (calc)
      cnt <= cnt_inc;
  end
`endif

endmodule

// File: tb/tb_gcd_unit_param.sv
// tb_gcd_unit_param: directed and randomized checks of gcd_unit_param
// against a Euclid reference model and hand-derived latencies.
module tb_gcd_unit_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        recv_val = 1'b0;
  logic        recv_rdy;
  logic [31:0] recv_msg = '0;
  logic        send_val;
  logic        send_rdy = 1'b0;
  logic [15:0] send_msg;

  logic        v32 = 1'b0, rdy32, sv32, sr32 = 1'b0;
  logic [63:0] m32 = '0;
  logic [31:0] sm32;
  logic        v8 = 1'b0, rdy8, sv8, sr8 = 1'b0;
  logic [15:0] m8 = '0;
  logic [7:0]  sm8;

`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
  logic [7:0] iters, iters32, iters8;
`endif

  gcd_unit_param #(.NBITS(16)) dut (
    .clk(clk), .reset(rst_n),
    .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
    .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg)
`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
    , .send_iters(iters)
`endif
  );

  gcd_unit_param #(.NBITS(32)) dut32 (
    .clk(clk), .reset(rst_n),
    .recv_val(v32), .recv_rdy(rdy32), .recv_msg(m32),
    .send_val(sv32), .send_rdy(sr32), .send_msg(sm32)
`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
    , .send_iters(iters32)
`endif
  );

  gcd_unit_param #(.NBITS(8)) dut8 (
    .clk(clk), .reset(rst_n),
    .recv_val(v8), .recv_rdy(rdy8), .recv_msg(m8),
    .send_val(sv8), .send_rdy(sr8), .send_msg(sm8)
`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
    , .send_iters(iters8)
`endif
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] q[$];
  logic [15:0] r[3];
  int          t[3];
  int          got;
  int          c_acc;
  int          nr;

  function automatic logic [31:0] gcd_ref(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y, m;
    x = a;
    y = b;
    while (y != 0) begin
      m = x % y;
      x = y;
      y = m;
    end
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_one(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp, input int lat);
    int k;
    chk("idle_rdy", recv_rdy, 1);
    recv_msg = {a, b};
    recv_val = 1'b1;
    send_rdy = 1'b1;
    @(negedge clk);
    recv_val = 1'b0;
    k = 1;
    while (!send_val && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk($sformatf("lat_%0d_%0d", a, b), k, lat);
    chk($sformatf("res_%0d_%0d", a, b), send_msg, exp);
`ifdef GCD_UNIT_PARAM_ITER_COUNT_EN
    chk($sformatf("iters_%0d_%0d", a, b), iters, lat);
`endif
    @(negedge clk);
    send_rdy = 1'b0;
    chk("released", send_val, 0);
  endtask

  task automatic push(input logic [15:0] a, input logic [15:0] b);
    int n;
    n = 0;
    recv_msg = {a, b};
    recv_val = 1'b1;
    while (!recv_rdy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("push_wait", n < 5000, 1);
    @(negedge clk);
    recv_val = 1'b0;
  endtask

  task automatic run_w(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    logic [31:0] obs;
    n = 0;
    if (w == 32) begin
      m32 = {a, b};
      v32 = 1'b1;
    end else begin
      m8 = {a[7:0], b[7:0]};
      v8 = 1'b1;
    end
    sr32 = 1'b1;
    sr8  = 1'b1;
    @(negedge clk);
    v32 = 1'b0;
    v8  = 1'b0;
    while (!((w == 32) ? sv32 : sv8) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    obs = (w == 32) ? sm32 : {24'd0, sm8};
    chk($sformatf("w%0d_wait", w), n < 2000, 1);
    chk($sformatf("w%0d_res", w), obs, exp);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdy", recv_rdy, 1);
    chk("rst_val", send_val, 0);
    chk("rst_msg", send_msg, 0);
    chk("rst_rdy32", rdy32, 1);
    chk("rst_val8", sv8, 0);
    rst_n = 1'b1;
    @(negedge clk);

    do_one(16'd15, 16'd5, 16'd5, 5);
    do_one(16'd0, 16'd0, 16'd0, 1);
    do_one(16'd0, 16'd7, 16'd7, 2);
    do_one(16'd9, 16'd0, 16'd9, 1);

    // back-to-back through the buffer, third request waits for the drain
    got = 0;
    c_acc = 0;
    fork
      begin
        int n;
        recv_msg = {16'd27, 16'd15};
        recv_val = 1'b1;
        @(negedge clk);
        chk("b2b_rdy_b", recv_rdy, 1);
        recv_msg = {16'd49, 16'd21};
        @(negedge clk);
        chk("b2b_full", recv_rdy, 0);
        recv_msg = {16'd12, 16'd18};
        n = 0;
        while (!recv_rdy && n < 500) begin
          @(negedge clk);
          n++;
        end
        c_acc = cyc;
        @(negedge clk);
        recv_val = 1'b0;
      end
      begin
        send_rdy = 1'b1;
        for (int n = 0; n < 2000 && got < 3; n++) begin
          @(negedge clk);
          if (send_val) begin
            r[got] = send_msg;
            t[got] = cyc;
            got++;
          end
        end
      end
    join
    send_rdy = 1'b0;
    chk("b2b_count", got, 3);
    chk("b2b_res0", r[0], 3);
    chk("b2b_res1", r[1], 7);
    chk("b2b_res2", r[2], 6);
    chk("b2b_gap1", t[1] - t[0], 7);
    chk("b2b_gap2", t[2] - t[1], 5);
    chk("b2b_c_acc", c_acc, t[0] + 1);
    @(negedge clk);

    // backpressure holds the result
    begin
      int n;
      recv_msg = {16'd12, 16'd18};
      recv_val = 1'b1;
      @(negedge clk);
      recv_val = 1'b0;
      n = 0;
      while (!send_val && n < 500) begin
        @(negedge clk);
        n++;
      end
      for (int i = 0; i < 4; i++) begin
        chk("bp_val", send_val, 1);
        chk("bp_msg", send_msg, 6);
        @(negedge clk);
      end
      chk("bp_hold", send_val, 1);
      send_rdy = 1'b1;
      @(negedge clk);
      chk("bp_release", send_val, 0);
      send_rdy = 1'b0;
    end

    // async reset while a result is pending and the buffer is full
    begin
      int n;
      recv_msg = {16'd49, 16'd21};
      recv_val = 1'b1;
      @(negedge clk);
      recv_msg = {16'd27, 16'd15};
      @(negedge clk);
      recv_val = 1'b0;
      chk("ar_full", recv_rdy, 0);
      n = 0;
      while (!send_val && n < 500) begin
        @(negedge clk);
        n++;
      end
      chk("ar_pending", send_val, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_val", send_val, 0);
      chk("ar_rdy", recv_rdy, 1);
      #4 rst_n = 1'b1;
      send_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        chk("ar_no_stale", send_val, 0);
      end
      send_rdy = 1'b0;
      do_one(16'd10, 16'd4, 16'd2, 6);
    end

    // random stream with random backpressure, order checked through a queue
    nr = 30;
    got = 0;
    fork
      begin
        logic [15:0] a, b;
        for (int i = 0; i < nr; i++) begin
          a = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
          b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 300));
          q.push_back(16'(gcd_ref({16'd0, a}, {16'd0, b})));
          push(a, b);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
      end
      begin
        for (int n = 0; n < 30000 && got < nr; n++) begin
          @(negedge clk);
          send_rdy = ($urandom_range(0, 3) != 0);
          if (send_val && send_rdy) begin
            if (q.size() == 0)
              chk("rnd_extra", 1, 0);
            else
              chk("rnd_res", send_msg, q.pop_front());
            got++;
          end
        end
      end
    join
    send_rdy = 1'b0;
    chk("rnd_count", got, nr);
    @(negedge clk);

    run_w(32, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    run_w(32, 32'hC000_0000, 32'h4000_0000, 32'h4000_0000);
    run_w(8, 32'd255, 32'd17, 32'd17);
    run_w(8, 32'd0, 32'd200, 32'd200);
    run_w(8, 32'd128, 32'd96, 32'd32);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
